// File: rtl/ex_muldiv.sv
// Iterative radix-2 RV32M multiply/divide unit for the EX stage.
// Works on operand magnitudes for 32 cycles, then applies the sign fix-up and presents the result for one capture cycle.
module ex_muldiv #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] rs1,
   input  logic [DATA_WIDTH-1:0] rs2,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  stall_req
);

   localparam int W = DATA_WIDTH;
   localparam logic [W-1:0] ALL_ONES  = {W{1'b1}};
   localparam logic [W-1:0] ALL_ZEROS = {W{1'b0}};
   localparam logic [W-1:0] MIN_NEG   = {1'b1, {(W-1){1'b0}}};
   localparam logic [5:0]   LAST_ITER = 6'(W-1);

   localparam logic [2:0] F_MUL    = 3'd0;
   localparam logic [2:0] F_MULH   = 3'd1;
   localparam logic [2:0] F_MULHSU = 3'd2;
   localparam logic [2:0] F_MULHU  = 3'd3;
   localparam logic [2:0] F_DIV    = 3'd4;
   localparam logic [2:0] F_DIVU   = 3'd5;
   localparam logic [2:0] F_REM    = 3'd6;
   localparam logic [2:0] F_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t         state_r, state_nxt_s;
   logic [2:0]     op_r;
   logic [5:0]     cnt_r;
   logic           neg_r;
   logic [W-1:0]   opd_r;       // multiplicand for MUL*, divisor for DIV*/REM*
   logic [2*W-1:0] acc_r;       // {partial product, multiplier} or {remainder, dividend/quotient}
   logic [W-1:0]   result_r;

   logic           accept_s;
   logic           sgn_a_s, sgn_b_s, neg_s;
   logic [W-1:0]   a_mag_s, b_mag_s;
   logic           div_zero_s, div_ovf_s, special_s;
   logic [W-1:0]   special_res_s;

   logic [W:0]     mul_sum_s;
   logic [W:0]     div_sh_s;
   logic [W-1:0]   div_diff_s;
   logic           div_q_s;
   logic [W-1:0]   div_rem_s;
   logic [2*W-1:0] acc_nxt_s;
   logic [2*W-1:0] prod_fix_s;
   logic [W-1:0]   quo_fix_s, rem_fix_s;
   logic [W-1:0]   final_s;

   assign accept_s = (state_r == ST_IDLE) & start & ~flush;

   // Operand decode at accept: sign flags, magnitudes and directly-known results.
   always_comb begin
      sgn_a_s       = 1'b0;
      sgn_b_s       = 1'b0;
      special_res_s = ALL_ZEROS;
      if (funct3[2]) begin
         sgn_a_s = rs1[W-1] & ~funct3[0];
         sgn_b_s = rs2[W-1] & ~funct3[0];
      end else begin
         sgn_a_s = rs1[W-1] & (funct3 != F_MULHU);
         sgn_b_s = rs2[W-1] & ~funct3[1];
      end
      a_mag_s    = sgn_a_s ? (ALL_ZEROS - rs1) : rs1;
      b_mag_s    = sgn_b_s ? (ALL_ZEROS - rs2) : rs2;
      // Remainder takes the dividend sign; everything else the XOR of both.
      neg_s      = (funct3[2] & funct3[1]) ? sgn_a_s : (sgn_a_s ^ sgn_b_s);
      div_zero_s = funct3[2] & (rs2 == ALL_ZEROS);
      div_ovf_s  = ((funct3 == F_DIV) || (funct3 == F_REM)) && (rs1 == MIN_NEG) && (rs2 == ALL_ONES);
      special_s  = div_zero_s | div_ovf_s;
      if (div_zero_s) begin
         special_res_s = funct3[1] ? rs1 : ALL_ONES;
      end else begin
         special_res_s = funct3[1] ? ALL_ZEROS : MIN_NEG;
      end
   end

   // One shift-add or restoring-divide step, plus the sign fix-up used on the last step.
   always_comb begin
      mul_sum_s  = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, opd_r} : {(W+1){1'b0}});
      div_sh_s   = {acc_r[2*W-1:W], acc_r[W-1]};
      div_q_s    = (div_sh_s >= {1'b0, opd_r});
      div_diff_s = div_sh_s[W-1:0] - opd_r;
      div_rem_s  = div_q_s ? div_diff_s : div_sh_s[W-1:0];
      if (op_r[2]) begin
         acc_nxt_s = {div_rem_s, acc_r[W-2:0], div_q_s};
      end else begin
         acc_nxt_s = {mul_sum_s, acc_r[W-1:1]};
      end
      prod_fix_s = neg_r ? ({(2*W){1'b0}} - acc_nxt_s) : acc_nxt_s;
      quo_fix_s  = neg_r ? (ALL_ZEROS - acc_nxt_s[W-1:0]) : acc_nxt_s[W-1:0];
      rem_fix_s  = neg_r ? (ALL_ZEROS - acc_nxt_s[2*W-1:W]) : acc_nxt_s[2*W-1:W];
      case (op_r)
         F_MUL:                      final_s = prod_fix_s[W-1:0];
         F_MULH, F_MULHSU, F_MULHU:  final_s = prod_fix_s[2*W-1:W];
         F_DIV, F_DIVU:              final_s = quo_fix_s;
         F_REM, F_REMU:              final_s = rem_fix_s;
         default:                    final_s = ALL_ZEROS;
      endcase
   end

   // Next-state logic; flush overrides every state.
   always_comb begin
      state_nxt_s = state_r;
      if (flush) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: state_nxt_s = start ? (special_s ? ST_DONE : ST_CALC) : ST_IDLE;
            ST_CALC: state_nxt_s = (cnt_r == LAST_ITER) ? ST_DONE : ST_CALC;
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Datapath registers: load on accept, iterate in CALC, hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r     <= 3'd0;
         cnt_r    <= 6'd0;
         neg_r    <= 1'b0;
         opd_r    <= ALL_ZEROS;
         acc_r    <= {(2*W){1'b0}};
         result_r <= ALL_ZEROS;
      end else if (accept_s) begin
         op_r  <= funct3;
         cnt_r <= 6'd0;
         neg_r <= neg_s;
         opd_r <= funct3[2] ? b_mag_s : a_mag_s;
         acc_r <= {ALL_ZEROS, (funct3[2] ? a_mag_s : b_mag_s)};
         if (special_s) begin
            result_r <= special_res_s;
         end
      end else if ((state_r == ST_CALC) && !flush) begin
         acc_r <= acc_nxt_s;
         cnt_r <= cnt_r + 6'd1;
         if (cnt_r == LAST_ITER) begin
            result_r <= final_s;
         end
      end
   end

   assign busy      = (state_r == ST_CALC);
   assign done      = (state_r == ST_DONE) & ~flush;
   assign stall_req = ((state_r == ST_IDLE) & start) | (state_r == ST_CALC);
   assign result    = result_r;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M vectors, randomized operations
// against an arithmetic reference model, and flush/reset abort scenarios.
module tb_ex_muldiv;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        stall_req;

   int          n_cmp;
   int          n_err;
   logic [31:0] last_res;

   ex_muldiv #(.DATA_WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .funct3    (funct3),
      .rs1       (rs1),
      .rs2       (rs2),
      .flush     (flush),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .stall_req (stall_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the RV32M definitions.
   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      int              ia, ib;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      ia = a;
      ib = b;
      case (f)
         3'd0: begin p = sa * sb;          return p[31:0];  end
         3'd1: begin p = sa * sb;          return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub;          return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return ia / ib;
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return ia % ib;
         end
         default: begin
            if (b == 32'd0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && (b == 32'd0)) return 1;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'd1;
         4:       return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   // Issue one operation and follow it to its done pulse, scrambling inputs meanwhile.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [31:0] exp;
      int          lat, cyc, stall_cnt;
      bit          seen;
      exp = ref_model(f, a, b);
      lat = ref_latency(f, a, b);
      @(negedge clk);
      funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
      #1;
      chk({tag, "_stall_start"}, stall_req, 32'd1);
      cyc = 0; stall_cnt = 1; seen = 1'b0;
      while (!seen && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) start = 1'b0;
         if (lat > 8 && cyc == 5) start = 1'b1;
         if (cyc == 6) start = 1'b0;
         funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
         #1;
         if (stall_req) stall_cnt++;
         if (cyc == 3 && lat > 3) chk({tag, "_hold_prev"}, result, last_res);
         if (done) seen = 1'b1;
      end
      chk({tag, "_latency"}, cyc, lat);
      chk({tag, "_result"}, result, exp);
      chk({tag, "_stall_cycles"}, stall_cnt, lat);
      chk({tag, "_busy_in_done"}, busy, 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk({tag, "_done_pulse"}, done, 32'd0);
      chk({tag, "_start_in_done_ignored"}, busy, 32'd0);
      chk({tag, "_result_held"}, result, exp);
      last_res = exp;
   endtask

   task automatic watch_no_done(input string tag, input int cycles);
      int hits;
      hits = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         #1;
         if (done || busy) hits++;
      end
      chk({tag, "_quiet"}, hits, 32'd0);
   endtask

   // Start a DIV and kill it around iteration 10 with flush or rst.
   task automatic abort_op(input bit use_rst, input string tag);
      @(negedge clk);
      funct3 = 3'd4; rs1 = $urandom; rs2 = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #1;
      chk({tag, "_busy_before"}, busy, 32'd1);
      if (use_rst) rst = 1'b1;
      else flush = 1'b1;
      #1;
      chk({tag, "_no_done"}, done, 32'd0);
      @(negedge clk);
      rst = 1'b0; flush = 1'b0;
      #1;
      if (use_rst) last_res = 32'd0;
      chk({tag, "_busy_after"}, busy, 32'd0);
      chk({tag, "_stall_after"}, stall_req, 32'd0);
      chk({tag, "_result"}, result, last_res);
      watch_no_done(tag, 40);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp = 0; n_err = 0; last_res = 32'd0;
      rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_busy", busy, 32'd0);
      chk("reset_done", done, 32'd0);
      chk("reset_result", result, 32'd0);
      chk("reset_stall", stall_req, 32'd0);
      rst = 1'b0;

      run_op(3'd0, 32'd7,         32'hFFFF_FFFD, "mul_7_m3");
      run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min");
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
      run_op(3'd2, 32'hFFFF_FFFF, 32'd2,         "mulhsu_m1_2");
      run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         "div_m7_2");
      run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         "rem_m7_2");
      run_op(3'd5, 32'd100,       32'd7,         "divu_100_7");
      run_op(3'd7, 32'd100,       32'd7,         "remu_100_7");
      run_op(3'd5, 32'h0000_1234, 32'd0,         "divu_by0");
      run_op(3'd7, 32'h0000_1234, 32'd0,         "remu_by0");
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
      run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, "divu_no_ovf");

      for (int i = 0; i < 40; i++) begin
         run_op(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), $sformatf("rnd%0d", i));
      end

      // flush while result is being presented
      @(negedge clk);
      funct3 = 3'd5; rs1 = 32'h55; rs2 = 32'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b1;
      #1;
      chk("flush_in_done_done", done, 32'd0);
      chk("flush_in_done_result", result, 32'hFFFF_FFFF);
      last_res = 32'hFFFF_FFFF;
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_in_done_idle", busy | done, 32'd0);

      // flush and start together: start must be dropped
      @(negedge clk);
      funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1;
      chk("flush_start_busy", busy, 32'd0);
      watch_no_done("flush_start", 40);
      chk("flush_start_result", result, last_res);

      abort_op(1'b0, "abort_flush");
      abort_op(1'b1, "abort_rst");
      run_op(3'd0, 32'd3, 32'd5, "mul_3_5_after_abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
